// File: rtl/cluster_addr_map_pkg.sv
// Shared definitions for the cluster address-map controller: crossbar rule
// type, configuration register offsets, STATUS bit positions, FSM states and
// the fixed cluster address-space constants.
package cluster_addr_map_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } xbar_rule_32_t;

    localparam logic [5:0] REG_CTRL      = 6'd0;
    localparam logic [5:0] REG_TCDM_SIZE = 6'd1;
    localparam logic [5:0] REG_DEFAULT   = 6'd2;
    localparam logic [5:0] REG_STATUS    = 6'd3;
    localparam logic [5:0] REG_USER_BASE = 6'd4;

    localparam int CTRL_COMMIT_BIT    = 0;
    localparam int CTRL_CLEAR_ERR_BIT = 1;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_CFG_ERR_BIT = 1;
    localparam int STATUS_CNT_ERR_BIT = 2;
    localparam int STATUS_TIMEOUT_BIT = 3;

    localparam logic [31:0] CLUSTER_BASE  = 32'h1000_0000;
    localparam logic [31:0] PERIPH_OFFSET = 32'h0020_0000;
    localparam logic [31:0] EXT_OFFSET    = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY
    } state_e;

    // Word address of field f (0=START, 1=END, 2=IDX) of user rule k.
    function automatic logic [5:0] user_reg_addr(input int k, input int f);
        return REG_USER_BASE + 6'(3 * k + f);
    endfunction

endpackage

// File: rtl/cluster_outstnd_cnt.sv
// Saturating outstanding-transaction counter. Increments on inc_i, decrements
// on dec_i; both together cancel. Underflow or overflow holds the value and
// pulses err_o for that cycle.
module cluster_outstnd_cnt #(
    parameter int unsigned MAX_OUTSTND = 16,
    parameter int unsigned CNT_W       = $clog2(MAX_OUTSTND + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    logic [CNT_W-1:0] cnt_reg;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_reg == CNT_W'(MAX_OUTSTND));
    assign at_zero = (cnt_reg == '0);
    assign err_o   = (inc_i & ~dec_i & at_max) | (dec_i & ~inc_i & at_zero);
    assign cnt_o   = cnt_reg;

    // Count up/down, holding at the limits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (inc_i && !dec_i && !at_max) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (dec_i && !inc_i && !at_zero) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cluster_addr_map_ctrl.sv
// Runtime-programmable address map for the cluster AXI crossbar. Updates are
// staged in a shadow register file and copied to the active map only after
// all slave-port transactions have drained and the shadow validates.
// Optional: define CLUSTER_ADDR_MAP_TIMEOUT_EN to abort a drain that takes
// longer than TIMEOUT_CYCLES.
module cluster_addr_map_ctrl
    import cluster_addr_map_pkg::*;
#(
    parameter int unsigned NB_SLV_PORTS    = 4,
    parameter int unsigned NB_MST_PORTS    = 3,
    parameter int unsigned NB_USER_RULES   = 4,
    parameter int unsigned MAX_OUTSTND     = 16,
    parameter int unsigned TCDM_SIZE_MAX   = 131072,
    parameter int unsigned RESET_TCDM_SIZE = 65536,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    localparam int unsigned IDX_W = (NB_MST_PORTS > 1) ? $clog2(NB_MST_PORTS) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [5:0]                             cluster_id_i,
    input  logic                                   cfg_req_i,
    output logic                                   cfg_gnt_o,
    input  logic                                   cfg_wen_i,
    input  logic [5:0]                             cfg_addr_i,
    input  logic [31:0]                            cfg_wdata_i,
    output logic [31:0]                            cfg_rdata_o,
    output logic                                   cfg_rvalid_o,
    input  logic [NB_SLV_PORTS-1:0]                aw_hs_i,
    input  logic [NB_SLV_PORTS-1:0]                b_hs_i,
    input  logic [NB_SLV_PORTS-1:0]                ar_hs_i,
    input  logic [NB_SLV_PORTS-1:0]                rlast_hs_i,
    output logic                                   stall_o,
    output xbar_rule_32_t [3+NB_USER_RULES:0]      addr_map_o,
    output logic [NB_SLV_PORTS-1:0]                en_default_mst_port_o,
    output logic [NB_SLV_PORTS-1:0][IDX_W-1:0]     default_mst_port_o,
    output logic                                   busy_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTND + 1);
    localparam int unsigned DEF_W = NB_SLV_PORTS * (1 + IDX_W);
    localparam int unsigned NB_UR = (NB_USER_RULES > 0) ? NB_USER_RULES : 1;

    state_e                               state_reg;
    logic [31:0]                          shadow_tcdm_reg, active_tcdm_reg;
    logic [DEF_W-1:0]                     shadow_default_reg, active_default_reg;
    logic [31:0]                          shadow_start_reg [NB_UR];
    logic [31:0]                          shadow_end_reg   [NB_UR];
    logic [31:0]                          shadow_idx_reg   [NB_UR];
    logic [31:0]                          active_start_reg [NB_UR];
    logic [31:0]                          active_end_reg   [NB_UR];
    logic [31:0]                          active_idx_reg   [NB_UR];
    logic                                 cfg_err_reg, cnt_err_reg, timeout_sts;
    logic [NB_SLV_PORTS-1:0][CNT_W-1:0]   wr_cnt, rd_cnt;
    logic [NB_SLV_PORTS-1:0]              wr_err, rd_err;
    logic                                 wr_en, commit_wr, clear_wr;
    logic                                 drained, shadow_valid, apply_ok;
    logic [31:0]                          base, rd_data, status;

    assign cfg_gnt_o = cfg_req_i;
    assign wr_en     = cfg_req_i & cfg_wen_i;
    assign commit_wr = wr_en && (cfg_addr_i == REG_CTRL) && cfg_wdata_i[CTRL_COMMIT_BIT];
    assign clear_wr  = wr_en && (cfg_addr_i == REG_CTRL) && cfg_wdata_i[CTRL_CLEAR_ERR_BIT];
    assign apply_ok  = (state_reg == ST_APPLY) && shadow_valid;
    assign base      = CLUSTER_BASE + ({26'd0, cluster_id_i} << 22);

    // Per-port write and read outstanding counters
    for (genvar gi = 0; gi < NB_SLV_PORTS; gi++) begin : g_cnt
        cluster_outstnd_cnt #(.MAX_OUTSTND(MAX_OUTSTND), .CNT_W(CNT_W)) u_wr_cnt (
            .clk_i(clk_i), .rst_i(rst_i), .inc_i(aw_hs_i[gi]), .dec_i(b_hs_i[gi]),
            .cnt_o(wr_cnt[gi]), .err_o(wr_err[gi])
        );
        cluster_outstnd_cnt #(.MAX_OUTSTND(MAX_OUTSTND), .CNT_W(CNT_W)) u_rd_cnt (
            .clk_i(clk_i), .rst_i(rst_i), .inc_i(ar_hs_i[gi]), .dec_i(rlast_hs_i[gi]),
            .cnt_o(rd_cnt[gi]), .err_o(rd_err[gi])
        );
    end

    // Drain is complete when every registered counter reads zero
    always_comb begin
        drained = 1'b1;
        for (int p = 0; p < NB_SLV_PORTS; p++) begin
            if (wr_cnt[p] != '0 || rd_cnt[p] != '0) drained = 1'b0;
        end
    end

    // Validate the shadow map before it may become active
    always_comb begin
        shadow_valid = 1'b1;
        if (shadow_tcdm_reg == '0 || shadow_tcdm_reg > 32'(TCDM_SIZE_MAX)) shadow_valid = 1'b0;
        for (int p = 0; p < NB_SLV_PORTS; p++) begin
            if (shadow_default_reg[p] &&
                32'(shadow_default_reg[NB_SLV_PORTS + p*IDX_W +: IDX_W]) >= 32'(NB_MST_PORTS))
                shadow_valid = 1'b0;
        end
        for (int k = 0; k < NB_USER_RULES; k++) begin
            if (shadow_idx_reg[k][31]) begin
                if ({1'b0, shadow_idx_reg[k][30:0]} >= 32'(NB_MST_PORTS)) shadow_valid = 1'b0;
                if (shadow_start_reg[k] >= shadow_end_reg[k]) shadow_valid = 1'b0;
            end
        end
    end

    // Shadow register file: accepts writes in every state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_tcdm_reg    <= 32'(RESET_TCDM_SIZE);
            shadow_default_reg <= '0;
            for (int k = 0; k < NB_UR; k++) begin
                shadow_start_reg[k] <= '0;
                shadow_end_reg[k]   <= '0;
                shadow_idx_reg[k]   <= '0;
            end
        end else if (wr_en) begin
            if (cfg_addr_i == REG_TCDM_SIZE) shadow_tcdm_reg <= cfg_wdata_i;
            if (cfg_addr_i == REG_DEFAULT) shadow_default_reg <= cfg_wdata_i[DEF_W-1:0];
            for (int k = 0; k < NB_USER_RULES; k++) begin
                if (cfg_addr_i == user_reg_addr(k, 0)) shadow_start_reg[k] <= cfg_wdata_i;
                if (cfg_addr_i == user_reg_addr(k, 1)) shadow_end_reg[k]   <= cfg_wdata_i;
                if (cfg_addr_i == user_reg_addr(k, 2)) shadow_idx_reg[k]   <= cfg_wdata_i;
            end
        end
    end

    // Active map: atomic copy of the shadow at the end of a valid APPLY cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_tcdm_reg    <= 32'(RESET_TCDM_SIZE);
            active_default_reg <= '0;
            for (int k = 0; k < NB_UR; k++) begin
                active_start_reg[k] <= '0;
                active_end_reg[k]   <= '0;
                active_idx_reg[k]   <= '0;
            end
        end else if (apply_ok) begin
            active_tcdm_reg    <= shadow_tcdm_reg;
            active_default_reg <= shadow_default_reg;
            for (int k = 0; k < NB_UR; k++) begin
                active_start_reg[k] <= shadow_start_reg[k];
                active_end_reg[k]   <= shadow_end_reg[k];
                active_idx_reg[k]   <= shadow_idx_reg[k];
            end
        end
    end

`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_reg;
`else
    assign timeout_sts = 1'b0;
`endif

    // Commit sequencer IDLE -> DRAIN -> APPLY -> IDLE with registered stall/busy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            busy_o      <= 1'b0;
            stall_o     <= 1'b0;
            cfg_err_reg <= 1'b0;
`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
            timer_reg   <= '0;
            timeout_sts <= 1'b0;
`endif
        end else begin
            if (clear_wr) begin
                cfg_err_reg <= 1'b0;
`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
                timeout_sts <= 1'b0;
`endif
            end
            case (state_reg)
                ST_IDLE: begin
                    if (commit_wr) begin
                        state_reg <= ST_DRAIN;
                        busy_o    <= 1'b1;
                        stall_o   <= 1'b1;
`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
                        timer_reg <= TMR_W'(TIMEOUT_CYCLES);
`endif
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state_reg <= ST_APPLY;
                    end
`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
                    else if (timer_reg == TMR_W'(1)) begin
                        state_reg   <= ST_IDLE;
                        busy_o      <= 1'b0;
                        stall_o     <= 1'b0;
                        timeout_sts <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - TMR_W'(1);
                    end
`endif
                end
                ST_APPLY: begin
                    state_reg <= ST_IDLE;
                    busy_o    <= 1'b0;
                    stall_o   <= 1'b0;
                    if (!shadow_valid) cfg_err_reg <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sticky counter error; a new error in the clearing cycle wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_err_reg <= 1'b0;
        end else if (|{wr_err, rd_err}) begin
            cnt_err_reg <= 1'b1;
        end else if (clear_wr) begin
            cnt_err_reg <= 1'b0;
        end
    end

    // Register read mux: shadow values, live STATUS, zero when unmapped
    always_comb begin
        status = '0;
        status[STATUS_BUSY_BIT]    = busy_o;
        status[STATUS_CFG_ERR_BIT] = cfg_err_reg;
        status[STATUS_CNT_ERR_BIT] = cnt_err_reg;
        status[STATUS_TIMEOUT_BIT] = timeout_sts;
        rd_data = '0;
        if (cfg_addr_i == REG_TCDM_SIZE) rd_data = shadow_tcdm_reg;
        if (cfg_addr_i == REG_DEFAULT)   rd_data = 32'(shadow_default_reg);
        if (cfg_addr_i == REG_STATUS)    rd_data = status;
        for (int k = 0; k < NB_USER_RULES; k++) begin
            if (cfg_addr_i == user_reg_addr(k, 0)) rd_data = shadow_start_reg[k];
            if (cfg_addr_i == user_reg_addr(k, 1)) rd_data = shadow_end_reg[k];
            if (cfg_addr_i == user_reg_addr(k, 2)) rd_data = shadow_idx_reg[k];
        end
    end

    // One-cycle response for every granted access; read data captured on reads
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            if (cfg_req_i && !cfg_wen_i) cfg_rdata_o <= rd_data;
        end
    end

    // Fixed cluster rules derived from the live base and active TCDM size
    assign addr_map_o[0] = '{idx: 32'd2, start_addr: 32'h0, end_addr: base};
    assign addr_map_o[1] = '{idx: 32'd2, start_addr: base + EXT_OFFSET, end_addr: 32'hFFFF_FFFF};
    assign addr_map_o[2] = '{idx: 32'd0, start_addr: base, end_addr: base + active_tcdm_reg};
    assign addr_map_o[3] = '{idx: 32'd1, start_addr: base + PERIPH_OFFSET, end_addr: base + EXT_OFFSET};

    // User rules; a disabled rule collapses to an empty range at zero
    for (genvar gi = 0; gi < NB_USER_RULES; gi++) begin : g_user_rule
        assign addr_map_o[4+gi] = active_idx_reg[gi][31] ?
            '{idx: {1'b0, active_idx_reg[gi][30:0]},
              start_addr: active_start_reg[gi], end_addr: active_end_reg[gi]} :
            '{idx: 32'd0, start_addr: 32'd0, end_addr: 32'd0};
    end

    // Default master port per slave port
    assign en_default_mst_port_o = active_default_reg[NB_SLV_PORTS-1:0];
    for (genvar gi = 0; gi < NB_SLV_PORTS; gi++) begin : g_default_port
        assign default_mst_port_o[gi] = active_default_reg[NB_SLV_PORTS + gi*IDX_W +: IDX_W];
    end

endmodule

// File: tb/tb_cluster_addr_map_ctrl.sv
// Directed bench for cluster_addr_map_ctrl. Register reads are scoreboarded:
// the expected value is queued when the access is driven and compared when
// cfg_rvalid_o returns. Build with CLUSTER_ADDR_MAP_TIMEOUT_EN to add the
// drain-timeout steps.
module tb_cluster_addr_map_ctrl;
    import cluster_addr_map_pkg::*;

    localparam int NB_SLV = 4;
    localparam int NB_UR  = 4;

    logic                         clk, rst;
    logic [5:0]                   cluster_id;
    logic                         cfg_req, cfg_gnt, cfg_wen, cfg_rvalid;
    logic [5:0]                   cfg_addr;
    logic [31:0]                  cfg_wdata, cfg_rdata;
    logic [NB_SLV-1:0]            aw_hs, b_hs, ar_hs, rlast_hs, en_default;
    logic                         stall, busy;
    xbar_rule_32_t [3+NB_UR:0]    addr_map;
    logic [NB_SLV-1:0][1:0]       default_port;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       tag_q[$];

    cluster_addr_map_ctrl #(
        .NB_SLV_PORTS(NB_SLV), .NB_MST_PORTS(3), .NB_USER_RULES(NB_UR),
        .MAX_OUTSTND(16), .TCDM_SIZE_MAX(131072), .RESET_TCDM_SIZE(65536),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cluster_id_i(cluster_id),
        .cfg_req_i(cfg_req), .cfg_gnt_o(cfg_gnt), .cfg_wen_i(cfg_wen),
        .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
        .cfg_rvalid_o(cfg_rvalid), .aw_hs_i(aw_hs), .b_hs_i(b_hs), .ar_hs_i(ar_hs),
        .rlast_hs_i(rlast_hs), .stall_o(stall), .addr_map_o(addr_map),
        .en_default_mst_port_o(en_default), .default_mst_port_o(default_port),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
        exp_q.push_back(32'd0); chk_q.push_back(1'b0); tag_q.push_back("write");
        cfg_req = 1'b1; cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
        check("gnt_write", {31'd0, cfg_gnt}, 32'd1);
        tick();
        cfg_req = 1'b0; cfg_wen = 1'b0;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic cfg_read(input logic [5:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e); chk_q.push_back(1'b1); tag_q.push_back(tag);
        cfg_req = 1'b1; cfg_wen = 1'b0; cfg_addr = a;
        tick();
        cfg_req = 1'b0;
        $display("read  addr=%0d expect=0x%08h (%s)", a, e, tag);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && busy; i++) tick();
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // Response monitor: pops the scoreboard whenever a response is returned
    always @(negedge clk) begin
        if (!rst && cfg_rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", {31'd0, cfg_rvalid}, 32'd0);
            end else begin
                logic [31:0] e;
                bit          c;
                string       t;
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                t = tag_q.pop_front();
                if (c) begin
                    check(t, cfg_rdata, e);
                    $display("resp  %s rdata=0x%08h", t, cfg_rdata);
                end
            end
        end
    end

    localparam logic [31:0] BASE = 32'h10C0_0000;

    initial begin
        rst = 1'b1; cluster_id = 6'd3;
        cfg_req = 0; cfg_wen = 0; cfg_addr = '0; cfg_wdata = '0;
        aw_hs = '0; b_hs = '0; ar_hs = '0; rlast_hs = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", {31'd0, cfg_rvalid}, 32'd0);
        check("rst_rdata", cfg_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Reset map
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("r0_end", addr_map[0].end_addr, BASE);
        check("r1_start", addr_map[1].start_addr, 32'h1100_0000);
        check("r1_end", addr_map[1].end_addr, 32'hFFFF_FFFF);
        check("r2_start", addr_map[2].start_addr, BASE);
        check("r2_end_rst", addr_map[2].end_addr, BASE + 32'h1_0000);
        check("r2_idx", addr_map[2].idx, 32'd0);
        check("r3_start", addr_map[3].start_addr, 32'h10E0_0000);
        check("r3_idx", addr_map[3].idx, 32'd1);
        check("u0_rst", addr_map[4].end_addr, 32'd0);
        check("en_def_rst", {28'd0, en_default}, 32'd0);
        cfg_read(REG_TCDM_SIZE, 32'h1_0000, "rd_tcdm_rst");
        cfg_read(REG_STATUS, 32'd0, "rd_status_rst");

        // Commit without traffic: DRAIN then APPLY, map updates afterwards
        cfg_write(REG_TCDM_SIZE, 32'h8000);
        cfg_write(REG_CTRL, 32'h1);
        check("drain_busy", {31'd0, busy}, 32'd1);
        check("drain_stall", {31'd0, stall}, 32'd1);
        tick();
        check("apply_busy", {31'd0, busy}, 32'd1);
        check("apply_map_old", addr_map[2].end_addr, BASE + 32'h1_0000);
        tick();
        check("post_apply_busy", {31'd0, busy}, 32'd0);
        check("post_apply_stall", {31'd0, stall}, 32'd0);
        check("r2_end_8000", addr_map[2].end_addr, BASE + 32'h8000);

        // Outstanding writes hold the drain until their responses return
        aw_hs = 4'b0010; tick(); tick(); aw_hs = '0;
        cfg_write(REG_TCDM_SIZE, 32'h4000);
        cfg_write(REG_CTRL, 32'h1);
        repeat (5) tick();
        check("held_stall", {31'd0, stall}, 32'd1);
        check("held_map", addr_map[2].end_addr, BASE + 32'h8000);
        b_hs = 4'b0010; tick(); tick(); b_hs = '0;
        check("drain_after_b", {31'd0, busy}, 32'd1);
        wait_idle("drain_done", 20);
        check("r2_end_4000", addr_map[2].end_addr, BASE + 32'h4000);
        cfg_read(REG_STATUS, 32'd0, "status_after_drain");

        // Oversized TCDM is rejected and the active map is kept
        cfg_write(REG_TCDM_SIZE, 32'h4_0000);
        cfg_write(REG_CTRL, 32'h1);
        wait_idle("bad_tcdm_idle", 20);
        check("bad_tcdm_map", addr_map[2].end_addr, BASE + 32'h4000);
        cfg_read(REG_STATUS, 32'h2, "status_cfg_err");
        cfg_write(REG_CTRL, 32'h2);
        cfg_read(REG_STATUS, 32'd0, "status_cleared");

        // Underflow sets cnt_err and leaves the count at zero
        b_hs = 4'b0001; tick(); b_hs = '0;
        cfg_read(REG_STATUS, 32'h4, "status_cnt_err");
        cfg_write(REG_TCDM_SIZE, 32'h2000);
        cfg_write(REG_CTRL, 32'h3);
        tick(); tick();
        check("underflow_no_hold", {31'd0, busy}, 32'd0);
        check("r2_end_2000", addr_map[2].end_addr, BASE + 32'h2000);
        cfg_read(REG_STATUS, 32'd0, "status_clr_cnt");

        // Simultaneous increment and decrement leaves the count unchanged
        aw_hs = 4'b0100; tick(); tick();
        b_hs = 4'b0100; tick();
        aw_hs = '0; tick(); tick();
        b_hs = '0;
        cfg_read(REG_STATUS, 32'd0, "status_balanced");
        cfg_write(REG_TCDM_SIZE, 32'h1000);
        cfg_write(REG_CTRL, 32'h1);
        tick(); tick();
        check("balanced_drain", {31'd0, busy}, 32'd0);
        check("r2_end_1000", addr_map[2].end_addr, BASE + 32'h1000);

        // User rule and default port
        cfg_write(user_reg_addr(0, 0), 32'h2000_0000);
        cfg_write(user_reg_addr(0, 1), 32'h3000_0000);
        cfg_write(user_reg_addr(0, 2), 32'h8000_0001);
        cfg_write(REG_DEFAULT, 32'h21);
        cfg_write(REG_CTRL, 32'h1);
        tick(); tick();
        check("u0_idx", addr_map[4].idx, 32'd1);
        check("u0_start", addr_map[4].start_addr, 32'h2000_0000);
        check("u0_end", addr_map[4].end_addr, 32'h3000_0000);
        check("en_def", {28'd0, en_default}, 32'h1);
        check("def_port0", {30'd0, default_port[0]}, 32'd2);
        cfg_read(user_reg_addr(0, 2), 32'h8000_0001, "rd_idx0");
        cfg_read(REG_DEFAULT, 32'h21, "rd_default");

        // Enabled user rule with out-of-range idx is rejected
        cfg_write(user_reg_addr(1, 0), 32'h4000_0000);
        cfg_write(user_reg_addr(1, 1), 32'h5000_0000);
        cfg_write(user_reg_addr(1, 2), 32'h8000_0003);
        cfg_write(REG_CTRL, 32'h1);
        wait_idle("bad_idx_idle", 20);
        check("u1_rejected", addr_map[5].end_addr, 32'd0);
        cfg_read(REG_STATUS, 32'h2, "status_bad_idx");
        cfg_write(user_reg_addr(1, 2), 32'h0);
        cfg_write(REG_CTRL, 32'h2);

        // Unmapped address
        cfg_write(6'd63, 32'hDEAD_BEEF);
        cfg_read(6'd63, 32'd0, "rd_unmapped");

        // A write landing in the APPLY cycle waits for the next commit
        cfg_write(REG_TCDM_SIZE, 32'h3000);
        cfg_write(REG_CTRL, 32'h1);
        tick();
        cfg_write(REG_TCDM_SIZE, 32'h5000);
        check("apply_write_busy", {31'd0, busy}, 32'd0);
        check("r2_end_3000", addr_map[2].end_addr, BASE + 32'h3000);
        cfg_read(REG_TCDM_SIZE, 32'h5000, "rd_tcdm_pending");

`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
        // Drain timeout after 8 cycles with one read outstanding
        ar_hs = 4'b1000; tick(); ar_hs = '0;
        cfg_write(REG_CTRL, 32'h1);
        repeat (7) tick();
        check("to_still_busy", {31'd0, busy}, 32'd1);
        tick();
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_stall", {31'd0, stall}, 32'd0);
        check("to_map", addr_map[2].end_addr, BASE + 32'h3000);
        cfg_read(REG_STATUS, 32'h8, "status_timeout");
        rlast_hs = 4'b1000; tick(); rlast_hs = '0;
        cfg_write(REG_CTRL, 32'h2);
`endif

        // Reset in the middle of a drain aborts and restores reset values
        ar_hs = 4'b1000; tick(); ar_hs = '0;
        cfg_write(REG_CTRL, 32'h1);
        tick();
        check("mid_drain_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_map", addr_map[2].end_addr, BASE + 32'h1_0000);
        check("rst_mid_user", addr_map[4].end_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        cfg_read(REG_TCDM_SIZE, 32'h1_0000, "rd_tcdm_after_rst");
        cfg_read(REG_STATUS, 32'd0, "status_after_rst");
        cfg_write(REG_CTRL, 32'h1);
        tick(); tick();
        check("rst_cnt_cleared", {31'd0, busy}, 32'd0);

        tick(); tick();
        check("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
